// File: rtl/usart_tx.sv
// rtl/usart_tx.sv - serial frame transmitter: start, LSB-first payload, CRC-8, parity, stop, idle gap
module usart_tx #(
  parameter int DATA_LENGTH  = 16,
  parameter int CRC_LENGTH   = 8,
  parameter int PARITY_CHECK = 1,
  parameter int PARITY_MODE  = 0,
  parameter int GAP_CYCLES   = 24
) (
  input  logic                   clk,
  input  logic                   rsnt,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   frame_done
);

  localparam int CNT_W = $clog2(DATA_LENGTH + CRC_LENGTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_LENGTH - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_LENGTH - 1);
  localparam logic [GAP_W-1:0] GAP_INIT   = GAP_W'(GAP_CYCLES);
  // The cycle in which tx_ready is high is itself the last line-high gap cycle.
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    CRC    = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                 state, state_next;
  logic [DATA_LENGTH-1:0] shreg, shreg_next;
  logic [7:0]             crc, crc_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [GAP_W-1:0]       gap, gap_next;
  logic                   par, par_next;
  logic                   tx_next, done_next;
  logic [2:0]             crc_idx;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign tx_ready = (state == IDLE) && (gap == '0);
  assign crc_idx  = cnt[2:0] + 3'd1;

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    crc_next   = crc;
    cnt_next   = cnt;
    gap_next   = gap;
    par_next   = par;
    tx_next    = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (gap != '0) gap_next = gap - GAP_W'(1);
        if (tx_valid && tx_ready) begin
          state_next = START;
          tx_next    = 1'b0;
          shreg_next = tx_data;
          crc_next   = 8'h00;
          par_next   = 1'(PARITY_MODE);
        end
      end
      START: begin
        state_next = DATA;
        tx_next    = shreg[0];
        shreg_next = shreg >> 1;
        crc_next   = crc_step(crc, shreg[0]);
        par_next   = par ^ shreg[0];
        cnt_next   = '0;
      end
      DATA: begin
        // crc already holds every data bit here; it stays frozen through CRC.
        if (cnt == DATA_LAST) begin
          state_next = CRC;
          tx_next    = crc[0];
          cnt_next   = '0;
        end else begin
          tx_next    = shreg[0];
          shreg_next = shreg >> 1;
          crc_next   = crc_step(crc, shreg[0]);
          par_next   = par ^ shreg[0];
          cnt_next   = cnt + CNT_W'(1);
        end
      end
      CRC: begin
        if (cnt == CRC_LAST) begin
          state_next = PARITY;
          tx_next    = (PARITY_CHECK != 0) ? (par ^ (^crc)) : 1'b1;
        end else begin
          tx_next  = crc[crc_idx];
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        state_next = STOP;
        done_next  = 1'b1;
      end
      STOP: begin
        state_next = IDLE;
        gap_next   = GAP_RELOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsnt) begin
      state      <= IDLE;
      shreg      <= '0;
      crc        <= 8'h00;
      cnt        <= '0;
      gap        <= GAP_INIT;
      par        <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      crc        <= crc_next;
      cnt        <= cnt_next;
      gap        <= gap_next;
      par        <= par_next;
      tx         <= tx_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: tb/tb_usart_tx.sv
// tb/tb_usart_tx.sv - bench for usart_tx: two parity modes side by side against a frame model
module tb_usart_tx;
  localparam int DL = 16;
  localparam int G  = 24;
  localparam int FL = DL + 8 + 3;

  logic          clk = 1'b0;
  logic          rsnt = 1'b1;
  logic          tx_valid = 1'b0;
  logic [DL-1:0] tx_data = '0;
  logic          tx_ready0, tx0, fd0, tx_ready1, tx1, fd1;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            idle_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usart_tx #(.PARITY_MODE(0)) dut0 (
    .clk(clk), .rsnt(rsnt), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready0), .tx(tx0), .frame_done(fd0));

  usart_tx #(.PARITY_MODE(1)) dut1 (
    .clk(clk), .rsnt(rsnt), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready1), .tx(tx1), .frame_done(fd1));

  // CRC as the remainder of M(x)*x^8 mod x^8+x^2+x+1, first transmitted bit = highest degree.
  function automatic logic [7:0] crc_ref(input logic [DL-1:0] d);
    logic [DL+7:0] r;
    r = '0;
    for (int i = 0; i < DL; i++) r[DL+7-i] = d[i];
    for (int i = DL + 7; i >= 8; i--)
      if (r[i]) r = r ^ ((DL+8)'(9'h107) << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [FL-1:0] frame_ref(input logic [DL-1:0] d, input logic mode);
    logic [FL-1:0] f;
    logic [7:0]    c;
    c = crc_ref(d);
    f[0]           = 1'b0;
    f[DL:1]        = d;
    f[DL+8:DL+1]   = c;
    f[DL+9]        = mode ^ (^d) ^ (^c);
    f[DL+10]       = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (tx_ready0 !== 1'b1 && n < 300) begin
      if (tx0 !== 1'b1 || fd0 !== 1'b0) idle_bad++;
      @(negedge clk);
      n++;
    end
  endtask

  // Entered at the negedge of the start-bit cycle; leaves at the first idle cycle.
  task automatic capture(input bit scramble, output logic [FL-1:0] f0, output logic [FL-1:0] f1,
                         output logic [FL-1:0] d0, output logic [FL-1:0] d1, output int rdy_hi);
    rdy_hi = 0;
    for (int i = 0; i < FL; i++) begin
      f0[i] = tx0; f1[i] = tx1; d0[i] = fd0; d1[i] = fd1;
      if (tx_ready0 || tx_ready1) rdy_hi++;
      if (scramble) begin
        tx_data  = DL'($urandom);
        tx_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [DL-1:0] d, input logic [FL-1:0] f0,
                             input logic [FL-1:0] f1, input logic [FL-1:0] d0,
                             input logic [FL-1:0] d1, input int rdy_hi);
    logic [FL-1:0] done_exp;
    done_exp = '0;
    done_exp[FL-1] = 1'b1;
    check({tag, "_even"}, 64'(f0), 64'(frame_ref(d, 1'b0)));
    check({tag, "_odd"}, 64'(f1), 64'(frame_ref(d, 1'b1)));
    check({tag, "_done0"}, 64'(d0), 64'(done_exp));
    check({tag, "_done1"}, 64'(d1), 64'(done_exp));
    check({tag, "_rdy_low"}, 64'(rdy_hi), 64'(0));
  endtask

  task automatic send(input string tag, input logic [DL-1:0] d, input bit scramble);
    int n, r;
    logic [FL-1:0] f0, f1, d0, d1;
    wait_ready(n);
    check({tag, "_ready"}, 64'(tx_ready0), 64'(1));
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    capture(scramble, f0, f1, d0, d1, r);
    tx_valid = 1'b0;
    check_frame(tag, d, f0, f1, d0, d1, r);
  endtask

  initial begin
    int n, r, t1, t2;
    logic [DL-1:0] w1, w2, d;
    logic [FL-1:0] f0, f1, d0, d1;

    // Reset with tx_valid asserted: must be ignored.
    tx_valid = 1'b1;
    tx_data  = DL'($urandom);
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx0), 64'(1));
    check("rst_ready", 64'(tx_ready0), 64'(0));
    check("rst_done", 64'(fd0), 64'(0));
    rsnt = 1'b0;
    tx_valid = 1'b0;
    wait_ready(n);
    check("rst_gap", 64'(n), 64'(G));

    send("zero", 16'h0000, 1'b0);
    send("one", 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) send("rand_scramble", DL'($urandom), 1'b1);
    send("ones", 16'hFFFF, 1'b0);

    // Back-to-back with tx_valid held high.
    w1 = DL'($urandom);
    w2 = ~w1;
    wait_ready(n);
    tx_data = w1;
    tx_valid = 1'b1;
    @(negedge clk);
    t1 = cyc;
    tx_data = w2;
    capture(1'b0, f0, f1, d0, d1, r);
    check_frame("b2b_first", w1, f0, f1, d0, d1, r);
    n = 0;
    while (tx0 !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    check("b2b_period", 64'(t2 - t1), 64'(FL + G));
    capture(1'b0, f0, f1, d0, d1, r);
    tx_valid = 1'b0;
    check_frame("b2b_second", w2, f0, f1, d0, d1, r);

    // Reset during the 5th data bit.
    d = DL'($urandom);
    wait_ready(n);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_bit4", 64'(tx0), 64'(d[4]));
    rsnt = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 64'(tx0), 64'(1));
    check("mid_rst_done", 64'(fd0 | fd1), 64'(0));
    rsnt = 1'b0;
    wait_ready(n);
    check("mid_rst_gap", 64'(n), 64'(G));
    send("after_rst", DL'($urandom), 1'b0);

    check("idle_line", 64'(idle_bad), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
